data_mem_responder: RTL and testbench

Multi-cycle data-memory responder for the RV32I core's load/store path. It accepts one request at a time over a valid/ready handshake. It waits a programmable number of cycles, then commits a store or performs a load with byte/half/word masking and sign/zero extension. It returns the result over a second valid/ready handshake. It replaces the zero-latency data memory when the core is moved to a stalling memory interface.

---
 rtl/data_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the RV32I load/store path.
// Accepts one request at a time, waits LATENCY edges, then commits a store or returns a masked load.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_maskmode,
  input  logic                  req_zext,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  input  logic                  rsp_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'd0,
    MODE_HALF = 2'd1,
    MODE_WORD = 2'd2,
    MODE_RSVD = 2'd3
  } mask_mode_t;

  state_t                  state;
  logic [CW-1:0]           cnt;

  logic                    cap_write;
  logic [DATA_WIDTH-1:0]   cap_addr;
  logic [DATA_WIDTH-1:0]   cap_wdata;
  mask_mode_t              cap_mode;
  logic                    cap_zext;

  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  logic [AW-1:0]           word_idx;
  logic                    out_of_range;
  logic                    acc_err;
  logic [3:0]              byte_en;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [7:0]              sel8;
  logic [15:0]             sel16;
  logic [DATA_WIDTH-1:0]   load_val;
  logic                    commit;
  logic                    mem_we;

  assign req_ready = (state == IDLE) && rstn;

  // The access happens on the last WAIT edge, using only the captured request.
  assign commit = (state == WAIT) && (cnt == CW'(1));
  assign mem_we = rstn && commit && cap_write && !acc_err;

  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_mode  <= mask_mode_t'(req_maskmode);
      cap_zext  <= req_zext;
    end
  end

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    word_idx     = cap_addr[AW+1:2];
    out_of_range = (cap_addr >> (AW + 2)) != '0;
    acc_err      = 1'b0;
    byte_en      = 4'b0000;
    wr_word      = '0;
    load_val     = '0;
    rd_word      = mem[word_idx];
    sel8         = 8'(rd_word >> {cap_addr[1:0], 3'b000});
    sel16        = cap_addr[1] ? rd_word[31:16] : rd_word[15:0];

    case (cap_mode)
      MODE_BYTE: begin
        byte_en  = 4'b0001 << cap_addr[1:0];
        wr_word  = {4{cap_wdata[7:0]}};
        load_val = {{24{sel8[7] & ~cap_zext}}, sel8};
      end
      MODE_HALF: begin
        acc_err  = cap_addr[0];
        byte_en  = cap_addr[1] ? 4'b1100 : 4'b0011;
        wr_word  = {2{cap_wdata[15:0]}};
        load_val = {{16{sel16[15] & ~cap_zext}}, sel16};
      end
      MODE_WORD: begin
        acc_err  = |cap_addr[1:0];
        byte_en  = 4'b1111;
        wr_word  = cap_wdata;
        load_val = rd_word;
      end
      default: begin
        acc_err  = 1'b1;
      end
    endcase

    acc_err = acc_err | out_of_range;
    if (acc_err || cap_write) begin
      load_val = '0;
    end
  end

  // NOTE: the array has no reset; contents survive rstn, and a store is dropped if rstn is low on its commit edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
        end
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cnt   <= CW'(LATENCY);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= load_val;
            rsp_err   <= acc_err;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: round-trips, masking/extension, errors,
// backpressure and reset while a request is pending.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_maskmode;
  logic        req_zext;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_ready;

  int n_total = 0;
  int n_pass  = 0;

  data_mem_responder #(
    .DATA_WIDTH (32),
    .DEPTH_WORDS(256),
    .LATENCY    (LAT)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_maskmode(req_maskmode),
    .req_zext    (req_zext),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_ready   (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] m, input logic z);
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = a;
    req_wdata    = d;
    req_maskmode = m;
    req_zext     = z;
  endtask

  task automatic scramble();
    req_valid    = 1'b0;
    req_write    = ~req_write;
    req_addr     = 32'hFFFF_FFFF;
    req_wdata    = 32'h5A5A_5A5A;
    req_maskmode = 2'd3;
    req_zext     = ~req_zext;
  endtask

  // Full transaction with rsp_ready high; called at a negedge while the DUT is idle.
  task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] m, input logic z,
                      input logic [31:0] exp_rd, input logic exp_err);
    check({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    drive(w, a, d, m, z);
    @(negedge clk);
    scramble();
    for (int i = 0; i < LAT; i++) begin
      check({tag, ".early_valid"}, {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    check({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, ".rdata"}, rsp_rdata, exp_rd);
    check({tag, ".err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    check({tag, ".busy_ready"}, {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check({tag, ".valid_clr"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  logic [31:0] held_rdata;

  initial begin
    rstn         = 1'b0;
    rsp_ready    = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_maskmode = '0;
    req_zext     = 1'b0;

    repeat (3) @(negedge clk);
    check("rst.req_ready", {31'b0, req_ready}, 32'd0);
    check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", {31'b0, rsp_err}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Word round-trip
    xfer("st_w10", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0, 1'b0);
    xfer("ld_w10", 1'b0, 32'h10, 32'h0, 2'd2, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Byte store (upper wdata bits must be ignored) and masked loads
    xfer("st_b11", 1'b1, 32'h11, 32'hAAAA_AA7F, 2'd0, 1'b0, 32'h0, 1'b0);
    xfer("ld_w10b", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEAD_7FEF, 1'b0);
    xfer("ld_b13s", 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 32'hFFFF_FFDE, 1'b0);
    xfer("ld_b13z", 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 32'h0000_00DE, 1'b0);
    xfer("ld_h12s", 1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 32'hFFFF_DEAD, 1'b0);
    xfer("ld_h10s", 1'b0, 32'h10, 32'h0, 2'd1, 1'b0, 32'h0000_7FEF, 1'b0);
    xfer("ld_b11s", 1'b0, 32'h11, 32'h0, 2'd0, 1'b0, 32'h0000_007F, 1'b0);

    // Half store into the upper lanes
    xfer("st_h16", 1'b1, 32'h16, 32'hFFFF_8001, 2'd1, 1'b0, 32'h0, 1'b0);
    xfer("st_h14", 1'b1, 32'h14, 32'h0000_1234, 2'd1, 1'b0, 32'h0, 1'b0);
    xfer("ld_w14", 1'b0, 32'h14, 32'h0, 2'd2, 1'b0, 32'h8001_1234, 1'b0);
    xfer("ld_h16z", 1'b0, 32'h16, 32'h0, 2'd1, 1'b1, 32'h0000_8001, 1'b0);

    // Errors
    xfer("ld_h11", 1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 32'h0, 1'b1);
    xfer("st_w12", 1'b1, 32'h12, 32'h1111_1111, 2'd2, 1'b0, 32'h0, 1'b1);
    xfer("ld_w10c", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEAD_7FEF, 1'b0);
    xfer("ld_w400", 1'b0, 32'h400, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1);
    xfer("ld_mm3", 1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1);
    xfer("st_w410", 1'b1, 32'h410, 32'h2222_2222, 2'd2, 1'b0, 32'h0, 1'b1);
    xfer("ld_w10d", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEAD_7FEF, 1'b0);

    // Top word of the array is in range
    xfer("st_w3fc", 1'b1, 32'h3FC, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0, 1'b0);
    xfer("ld_w3fc", 1'b0, 32'h3FC, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0);

    // Backpressure: response held for 5 cycles
    rsp_ready = 1'b0;
    drive(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    @(negedge clk);
    scramble();
    repeat (LAT) @(negedge clk);
    check("bp.valid", {31'b0, rsp_valid}, 32'd1);
    check("bp.rdata", rsp_rdata, 32'hDEAD_7FEF);
    held_rdata = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp.hold_rdata", rsp_rdata, 32'hDEAD_7FEF);
      check("bp.hold_err", {31'b0, rsp_err}, 32'd0);
      check("bp.hold_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp.rel_valid", {31'b0, rsp_valid}, 32'd0);
    check("bp.rel_rdata", rsp_rdata, 32'd0);
    check("bp.rel_ready", {31'b0, req_ready}, 32'd1);

    // Reset one cycle before the commit edge
    xfer("st_w20z", 1'b1, 32'h20, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h20, 32'h1234_5678, 2'd2, 1'b0);
    @(negedge clk);
    scramble();
    rstn = 1'b0;
    @(negedge clk);
    check("rmid.req_ready", {31'b0, req_ready}, 32'd0);
    check("rmid.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rmid.rsp_rdata", rsp_rdata, 32'd0);
    check("rmid.rsp_err", {31'b0, rsp_err}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rmid.ready_back", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("rmid.no_rsp", {31'b0, rsp_valid}, 32'd0);
    xfer("ld_w20a", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);

    // Reset exactly on the commit edge
    drive(1'b1, 32'h20, 32'hABCD_0000, 2'd2, 1'b0);
    @(negedge clk);
    scramble();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("rcom.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    xfer("ld_w20b", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
